// File: rtl/width_conv_fifo.sv
// width_conv_fifo: synchronous FIFO taking RATIO-lane wide writes and returning narrow reads, LSB lane first.
// Define WCF_ERR_FLAGS_EN to add sticky ovf/udf error flags.
module width_conv_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int RATIO      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr,
    input  logic [RATIO*DATA_WIDTH-1:0] w_data,
    output logic                        full,
    input  logic                        rd,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        empty,
    output logic [ADDR_WIDTH:0]         level
`ifdef WCF_ERR_FLAGS_EN
    ,
    output logic                        ovf,
    output logic                        udf
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_THRESH = (ADDR_WIDTH+1)'(DEPTH - RATIO);
    localparam logic [ADDR_WIDTH:0]   LEVEL_STEP  = (ADDR_WIDTH+1)'(RATIO);
    // Truncation is intended: with RATIO == DEPTH the write pointer stays at 0.
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP    = ADDR_WIDTH'(RATIO);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  wa;
    logic                  ra;

    always_comb begin
        full    = (level_q > FULL_THRESH);
        empty   = (level_q == '0);
        wa      = wr & ~full;
        ra      = rd & ~empty;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        if (wa) begin
            w_ptr_d = w_ptr_q + PTR_STEP;
        end
        if (ra) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
        level_d = level_q + (wa ? LEVEL_STEP : '0) - (ra ? (ADDR_WIDTH+1)'(1) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
        end
    end

    // w_ptr is always RATIO-aligned, so the lanes of one write never straddle the wrap.
    always_ff @(posedge clk) begin
        if (wa) begin
            for (int k = 0; k < RATIO; k++) begin
                mem[w_ptr_q + ADDR_WIDTH'(k)] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign r_data = mem[r_ptr_q];
    assign level  = level_q;

`ifdef WCF_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wr & full);
        udf_d = udf_q | (rd & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule

// File: tb/tb_width_conv_fifo.sv
// tb_width_conv_fifo: directed vectors on the default 8/3/2 configuration plus a random
// wrap run against a queue model on an 8/4/4 instance.
module tb_width_conv_fifo;

    logic        clk;
    logic        rst_n;

    logic        a_wr, a_rd;
    logic [15:0] a_w_data;
    logic        a_full, a_empty;
    logic [7:0]  a_r_data;
    logic [3:0]  a_level;

    logic        b_wr, b_rd;
    logic [31:0] b_w_data;
    logic        b_full, b_empty;
    logic [7:0]  b_r_data;
    logic [4:0]  b_level;

`ifdef WCF_ERR_FLAGS_EN
    logic a_ovf, a_udf, b_ovf, b_udf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    width_conv_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RATIO(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr(a_wr), .w_data(a_w_data), .full(a_full),
        .rd(a_rd), .r_data(a_r_data), .empty(a_empty), .level(a_level)
`ifdef WCF_ERR_FLAGS_EN
        , .ovf(a_ovf), .udf(a_udf)
`endif
    );

    width_conv_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RATIO(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr(b_wr), .w_data(b_w_data), .full(b_full),
        .rd(b_rd), .r_data(b_r_data), .empty(b_empty), .level(b_level)
`ifdef WCF_ERR_FLAGS_EN
        , .ovf(b_ovf), .udf(b_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] w_data;
        int          exp_level;
        logic        exp_empty;
        logic        exp_full;
        logic        chk_rdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic rd, logic [15:0] d, int lvl,
                                logic emp, logic ful, logic chk, logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.w_data = d; v.exp_level = lvl;
        v.exp_empty = emp; v.exp_full = ful; v.chk_rdata = chk; v.exp_rdata = rdat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive instance A inputs, clock one edge, and settle just past it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] d);
        a_wr = wr;
        a_rd = rd;
        a_w_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        byte unsigned model[$];
        int  idx;

        rst_n = 1'b0;
        a_wr = 1'b1; a_rd = 1'b1; a_w_data = 16'hBBAA;
        b_wr = 1'b0; b_rd = 1'b0; b_w_data = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_empty", 32'(a_empty), 32'd1);
        checkOutput("reset_full",  32'(a_full),  32'd0);
        checkOutput("reset_level", 32'(a_level), 32'd0);
`ifdef WCF_ERR_FLAGS_EN
        checkOutput("reset_ovf", 32'(a_ovf), 32'd0);
        checkOutput("reset_udf", 32'(a_udf), 32'd0);
`endif

        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'hBBAA);
        checkOutput("first_wr_level", 32'(a_level),  32'd2);
        checkOutput("first_wr_empty", 32'(a_empty),  32'd0);
        checkOutput("first_wr_rdata", 32'(a_r_data), 32'hAA);

        // Lane order
        vecs.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 1, 8'hBB));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 0, 8'h00));
        // Fill and reject
        vecs.push_back(mk(1, 0, 16'h1100, 2, 0, 0, 1, 8'h00));
        vecs.push_back(mk(1, 0, 16'h3322, 4, 0, 0, 1, 8'h00));
        vecs.push_back(mk(1, 0, 16'h5544, 6, 0, 0, 1, 8'h00));
        vecs.push_back(mk(1, 0, 16'h7766, 8, 0, 1, 1, 8'h00));
        vecs.push_back(mk(1, 0, 16'h9988, 8, 0, 1, 1, 8'h00));
        vecs.push_back(mk(0, 1, 16'h0000, 7, 0, 1, 1, 8'h11));
        vecs.push_back(mk(0, 1, 16'h0000, 6, 0, 0, 1, 8'h22));
        vecs.push_back(mk(0, 1, 16'h0000, 5, 0, 0, 1, 8'h33));
        vecs.push_back(mk(0, 1, 16'h0000, 4, 0, 0, 1, 8'h44));
        vecs.push_back(mk(0, 1, 16'h0000, 3, 0, 0, 1, 8'h55));
        vecs.push_back(mk(0, 1, 16'h0000, 2, 0, 0, 1, 8'h66));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 1, 8'h77));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 0, 8'h00));
        // Read while empty is dropped
        vecs.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 0, 8'h00));
        // Simultaneous read/write around the full threshold
        vecs.push_back(mk(1, 0, 16'hA1A0, 2, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(1, 0, 16'hA3A2, 4, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(1, 0, 16'hA5A4, 6, 0, 0, 1, 8'hA0));
        vecs.push_back(mk(1, 1, 16'hB1B0, 7, 0, 1, 1, 8'hA1));
        vecs.push_back(mk(1, 1, 16'hC1C0, 6, 0, 0, 1, 8'hA2));
        vecs.push_back(mk(0, 1, 16'h0000, 5, 0, 0, 1, 8'hA3));
        vecs.push_back(mk(0, 1, 16'h0000, 4, 0, 0, 1, 8'hA4));
        vecs.push_back(mk(0, 1, 16'h0000, 3, 0, 0, 1, 8'hA5));
        vecs.push_back(mk(0, 1, 16'h0000, 2, 0, 0, 1, 8'hB0));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 0, 0, 1, 8'hB1));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].w_data);
            checkOutput($sformatf("vec%0d_level", i), 32'(a_level), 32'(vecs[i].exp_level));
            checkOutput($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(vecs[i].exp_empty));
            checkOutput($sformatf("vec%0d_full", i),  32'(a_full),  32'(vecs[i].exp_full));
            if (vecs[i].chk_rdata) begin
                checkOutput($sformatf("vec%0d_rdata", i), 32'(a_r_data), 32'(vecs[i].exp_rdata));
            end
        end

`ifdef WCF_ERR_FLAGS_EN
        checkOutput("sticky_ovf", 32'(a_ovf), 32'd1);
        checkOutput("sticky_udf", 32'(a_udf), 32'd1);
`endif

        // Asynchronous reset mid-operation discards stored data
        applyStimulus(1'b1, 1'b0, 16'h4433);
        checkOutput("pre_rst_level", 32'(a_level), 32'd2);
        a_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_level", 32'(a_level), 32'd0);
        checkOutput("async_rst_empty", 32'(a_empty), 32'd1);
        checkOutput("async_rst_full",  32'(a_full),  32'd0);
`ifdef WCF_ERR_FLAGS_EN
        checkOutput("async_rst_ovf", 32'(a_ovf), 32'd0);
        checkOutput("async_rst_udf", 32'(a_udf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic on the 4:1, depth-16 instance against a queue model
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic wr_r, rd_r, wa_m, ra_m;
            logic [31:0] d;
            checkOutput($sformatf("wrap%0d_level", cyc), 32'(b_level), 32'(model.size()));
            checkOutput($sformatf("wrap%0d_empty", cyc), 32'(b_empty), 32'(model.size() == 0));
            checkOutput($sformatf("wrap%0d_full", cyc),  32'(b_full),  32'(model.size() > 12));
            if (model.size() > 0) begin
                checkOutput($sformatf("wrap%0d_rdata", cyc), 32'(b_r_data), 32'(model[0]));
            end
            wr_r = ($urandom_range(0, 9) < 6);
            rd_r = ($urandom_range(0, 9) < 7);
            d = $urandom;
            wa_m = wr_r && (model.size() <= 12);
            ra_m = rd_r && (model.size() > 0);
            b_wr = wr_r;
            b_rd = rd_r;
            b_w_data = d;
            if (ra_m) void'(model.pop_front());
            if (wa_m) begin
                for (int k = 0; k < 4; k++) model.push_back(d[k*8 +: 8]);
            end
            @(posedge clk);
            #1;
        end

        b_wr = 1'b0;
        b_rd = 1'b0;
        idx = 0;
        while (model.size() > 0 && idx < 20) begin
            checkOutput($sformatf("drain%0d_level", idx), 32'(b_level),  32'(model.size()));
            checkOutput($sformatf("drain%0d_rdata", idx), 32'(b_r_data), 32'(model[0]));
            b_rd = 1'b1;
            void'(model.pop_front());
            @(posedge clk);
            #1;
            idx++;
        end
        b_rd = 1'b0;
        checkOutput("drain_bound", 32'(model.size()), 32'd0);
        checkOutput("drain_empty", 32'(b_empty), 32'd1);
        checkOutput("drain_level", 32'(b_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
